fsm_vector_checker: RTL and testbench

//  Hardware stimulus/check engine: the driving end of the 2-bit-in / 3-bit-out FSM lab interface.

---
 rtl/fsm_chk_pkg.sv | 46 ++++
 rtl/fsm_vector_checker_if.sv | 28 ++
 rtl/fsm_chk_vec_rom.sv | 29 ++
 rtl/fsm_vector_checker.sv | 163 ++++++++++++++++
 tb/tb_fsm_vector_checker.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_chk_pkg.sv
// fsm_chk_pkg -- shared types and constants for the FSM vector checker.
//   NUM_VEC   : number of vectors in the replay table
//   IDX_W     : vector index width
//   CNT_W     : pass/fail counter width (holds 0..NUM_VEC without wrapping)
//   state_t   : checker FSM states
//   vec_t     : one table entry {rst, in, exp_out, exp_state}
//   VEC_TABLE : default replay table for the 2-bit-in / 3-bit-out lab FSM
package fsm_chk_pkg;

  localparam int NUM_VEC = 12;
  localparam int IDX_W   = $clog2(NUM_VEC);
  localparam int CNT_W   = $clog2(NUM_VEC + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic       rst;
    logic [1:0] in;
    logic [2:0] exp_out;
    logic [2:0] exp_state;
  } vec_t;

  // Three short walks through the lab FSM, each beginning with a reset.
  localparam vec_t VEC_TABLE [NUM_VEC] = '{
    '{1'b1, 2'b00, 3'b101, 3'd0},
    '{1'b0, 2'b11, 3'b010, 3'd1},
    '{1'b0, 2'b01, 3'b001, 3'd2},
    '{1'b0, 2'b00, 3'b001, 3'd2},
    '{1'b1, 2'b00, 3'b101, 3'd0},
    '{1'b0, 2'b11, 3'b010, 3'd1},
    '{1'b0, 2'b11, 3'b101, 3'd3},
    '{1'b0, 2'b00, 3'b001, 3'd2},
    '{1'b1, 2'b00, 3'b101, 3'd0},
    '{1'b0, 2'b11, 3'b010, 3'd1},
    '{1'b0, 2'b00, 3'b011, 3'd4},
    '{1'b0, 2'b11, 3'b101, 3'd3}
  };

endpackage

// File: rtl/fsm_vector_checker_if.sv
// fsm_vector_checker_if -- link between the checker and the lab FSM under test.
//   dut_reset : synchronous reset into the FSM (checker -> FSM)
//   dut_in    : 2-bit FSM input               (checker -> FSM)
//   dut_out   : 3-bit FSM output              (FSM -> checker)
//   dut_state : 3-bit FSM current-state code  (FSM -> checker)
// Modports: master = checker side, slave = FSM side.
interface fsm_vector_checker_if;

  logic       dut_reset;
  logic [1:0] dut_in;
  logic [2:0] dut_out;
  logic [2:0] dut_state;

  modport master (
    output dut_reset,
    output dut_in,
    input  dut_out,
    input  dut_state
  );

  modport slave (
    input  dut_reset,
    input  dut_in,
    output dut_out,
    output dut_state
  );

endinterface

// File: rtl/fsm_chk_vec_rom.sv
// fsm_chk_vec_rom -- combinational lookup of the replay table.
//   idx : vector index
//   vec : table entry at idx (all zeros for indices past the table end)
module fsm_chk_vec_rom
  import fsm_chk_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output vec_t             vec
);

  localparam int ROM_DEPTH = 2 ** IDX_W;

  // Padded to a power of two so every idx value selects a defined entry.
  vec_t rom [ROM_DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
      if (gi < NUM_VEC) begin : g_used
        assign rom[gi] = VEC_TABLE[gi];
      end else begin : g_pad
        assign rom[gi] = '0;
      end
    end
  endgenerate

  assign vec = rom[idx];

endmodule

// File: rtl/fsm_vector_checker.sv
// fsm_vector_checker -- replays the vector table into the lab FSM and scores
// its response, one vector per clock, for on-board self-test.
//   clk            : clock shared with the FSM under test
//   reset_n        : asynchronous active-low reset
//   start          : one-cycle pulse, begins a run from vector 0 (IDLE/DONE)
//   dut_bus        : master side of fsm_vector_checker_if
//   busy           : high in RUN and DRAIN
//   done           : high in DONE until the next start
//   pass_cnt       : vectors that matched
//   fail_cnt       : vectors that mismatched
//   any_fail       : sticky, set on the first mismatch of the run
//   first_fail_idx : index of the first mismatch, 0 if none
// Optional build macro FSM_CHK_STOP_ON_FAIL_EN: end the run at the first
// mismatch (the vector already driven behind it is never scored).
module fsm_vector_checker
  import fsm_chk_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  fsm_vector_checker_if.master  dut_bus,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic                  any_fail,
  output logic [IDX_W-1:0]      first_fail_idx
);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;

  // Check stage: holds the expectation of the vector the FSM consumed at the
  // last edge, so the comparison lines up with the FSM's registered response.
  logic             chk_valid_reg, chk_valid_next;
  logic [2:0]       chk_out_reg, chk_out_next;
  logic [2:0]       chk_state_reg, chk_state_next;
  logic [IDX_W-1:0] chk_idx_reg, chk_idx_next;

  logic [CNT_W-1:0] pass_cnt_reg, pass_cnt_next;
  logic [CNT_W-1:0] fail_cnt_reg, fail_cnt_next;
  logic             any_fail_reg, any_fail_next;
  logic [IDX_W-1:0] first_fail_reg, first_fail_next;

  logic             drv_reset;
  logic [1:0]       drv_in;
  vec_t             cur_vec;
  logic             chk_match;

  fsm_chk_vec_rom u_rom (
    .idx (idx_reg),
    .vec (cur_vec)
  );

  assign chk_match = (dut_bus.dut_out == chk_out_reg) &&
                     (dut_bus.dut_state == chk_state_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      chk_valid_reg  <= 1'b0;
      chk_out_reg    <= '0;
      chk_state_reg  <= '0;
      chk_idx_reg    <= '0;
      pass_cnt_reg   <= '0;
      fail_cnt_reg   <= '0;
      any_fail_reg   <= 1'b0;
      first_fail_reg <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      chk_valid_reg  <= chk_valid_next;
      chk_out_reg    <= chk_out_next;
      chk_state_reg  <= chk_state_next;
      chk_idx_reg    <= chk_idx_next;
      pass_cnt_reg   <= pass_cnt_next;
      fail_cnt_reg   <= fail_cnt_next;
      any_fail_reg   <= any_fail_next;
      first_fail_reg <= first_fail_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    chk_valid_next  = chk_valid_reg;
    chk_out_next    = chk_out_reg;
    chk_state_next  = chk_state_reg;
    chk_idx_next    = chk_idx_reg;
    pass_cnt_next   = pass_cnt_reg;
    fail_cnt_next   = fail_cnt_reg;
    any_fail_next   = any_fail_reg;
    first_fail_next = first_fail_reg;
    drv_reset       = 1'b0;
    drv_in          = 2'b00;

    // Score the pending vector; valid is only ever set while RUN/DRAIN.
    if (chk_valid_reg) begin
      if (chk_match) begin
        pass_cnt_next = pass_cnt_reg + CNT_W'(1);
      end else begin
        fail_cnt_next = fail_cnt_reg + CNT_W'(1);
        if (!any_fail_reg) begin
          any_fail_next   = 1'b1;
          first_fail_next = chk_idx_reg;
        end
      end
    end

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next      = RUN;
          idx_next        = '0;
          chk_valid_next  = 1'b0;
          pass_cnt_next   = '0;
          fail_cnt_next   = '0;
          any_fail_next   = 1'b0;
          first_fail_next = '0;
        end
      end
      RUN: begin
        drv_reset      = cur_vec.rst;
        drv_in         = cur_vec.in;
        chk_valid_next = 1'b1;
        chk_out_next   = cur_vec.exp_out;
        chk_state_next = cur_vec.exp_state;
        chk_idx_next   = idx_reg;
        if (idx_reg == LAST_IDX) begin
          state_next = DRAIN;
        end else begin
          idx_next = idx_reg + IDX_W'(1);
        end
`ifdef FSM_CHK_STOP_ON_FAIL_EN
        // Abandon the vector being driven right now; it is never scored.
        if (chk_valid_reg && !chk_match) begin
          state_next     = DONE;
          chk_valid_next = 1'b0;
        end
`endif
      end
      DRAIN: begin
        chk_valid_next = 1'b0;
        state_next     = DONE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign dut_bus.dut_reset = drv_reset;
  assign dut_bus.dut_in    = drv_in;

  assign busy           = (state_reg == RUN) || (state_reg == DRAIN);
  assign done           = (state_reg == DONE);
  assign pass_cnt       = pass_cnt_reg;
  assign fail_cnt       = fail_cnt_reg;
  assign any_fail       = any_fail_reg;
  assign first_fail_idx = first_fail_reg;

endmodule

// File: tb/tb_fsm_vector_checker.sv
// tb_fsm_vector_checker -- drives the checker against a behavioural lab FSM
// with selectable faults and observation corruption; expectations come from
// hand-derived tables and from a vector-by-vector scoring model.
module tb_fsm_vector_checker;
  import fsm_chk_pkg::*;

`ifdef FSM_CHK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             any_fail;
  logic [IDX_W-1:0] first_fail_idx;

  fsm_vector_checker_if bus ();

  fsm_vector_checker u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .dut_bus        (bus),
    .busy           (busy),
    .done           (done),
    .pass_cnt       (pass_cnt),
    .fail_cnt       (fail_cnt),
    .any_fail       (any_fail),
    .first_fail_idx (first_fail_idx)
  );

  // Independent copy of the table: {rst, in[1:0], out[2:0], state[2:0]}.
  logic [8:0] tv [12] = '{
    9'b1_00_101_000, 9'b0_11_010_001, 9'b0_01_001_010, 9'b0_00_001_010,
    9'b1_00_101_000, 9'b0_11_010_001, 9'b0_11_101_011, 9'b0_00_001_010,
    9'b1_00_101_000, 9'b0_11_010_001, 9'b0_00_011_100, 9'b0_11_101_011
  };

  // Lab FSM. fault 1: state 1 with in=00 goes to 3 instead of 4.
  // fault 2: out[0] stuck at 0.
  int         fault_mode = 0;
  logic [5:0] corrupt    = '0;
  logic [5:0] mask [12];
  logic [2:0] lab_state  = '0;

  function automatic logic [2:0] lab_next(input logic [2:0] s, input logic [1:0] i, input int f);
    logic [2:0] n;
    n = 3'd0;
    case (s)
      3'd0: n = (i == 2'b11) ? 3'd1 : 3'd0;
      3'd1: begin
        case (i)
          2'b01:   n = 3'd2;
          2'b11:   n = 3'd3;
          2'b00:   n = (f == 1) ? 3'd3 : 3'd4;
          default: n = 3'd0;
        endcase
      end
      3'd2: n = (i == 2'b00) ? 3'd2 : 3'd0;
      3'd3: n = (i == 2'b00) ? 3'd2 : ((i == 2'b11) ? 3'd1 : 3'd0);
      3'd4: n = (i == 2'b11) ? 3'd3 : 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] obs_out(input logic [2:0] s, input int f);
    logic [2:0] o;
    case (s)
      3'd0: o = 3'b101;
      3'd1: o = 3'b010;
      3'd2: o = 3'b001;
      3'd3: o = 3'b101;
      3'd4: o = 3'b011;
      default: o = 3'b000;
    endcase
    if (f == 2) o[0] = 1'b0;
    return o;
  endfunction

  always @(posedge clk)
    lab_state <= bus.dut_reset ? 3'd0 : lab_next(lab_state, bus.dut_in, fault_mode);

  assign bus.dut_out   = obs_out(lab_state, fault_mode) ^ corrupt[5:3];
  assign bus.dut_state = lab_state ^ corrupt[2:0];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoring model: walk the table, compute what the FSM shows for each vector
  // and count matches; stop-on-fail truncates after the first mismatch.
  task automatic model_run(input int f, output int p, output int n, output int first);
    logic [2:0] s;
    logic [5:0] obs;
    s = 3'd0; p = 0; n = 0; first = -1;
    for (int k = 0; k < 12; k++) begin
      s   = tv[k][8] ? 3'd0 : lab_next(s, tv[k][7:6], f);
      obs = {obs_out(s, f), s} ^ mask[k];
      if (obs != tv[k][5:0]) begin
        n++;
        if (first < 0) first = k;
        if (STOP) break;
      end else begin
        p++;
      end
    end
    if (first < 0) first = 0;
  endtask

  task automatic do_run(input string tag, input bit pulse_mid,
                        input int exp_p, input int exp_f, input int exp_first);
    int done_exp;
    int done_at;
    int drv_exp;
    done_exp = (STOP && exp_f > 0) ? exp_first + 2 : 13;
    done_at  = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    corrupt = '0;
    check({tag, " busy_after_start"}, int'(busy), 1);
    check({tag, " cleared_after_start"}, int'({done, any_fail, pass_cnt, fail_cnt}), 0);
    check({tag, " drive_vec0"}, int'({bus.dut_reset, bus.dut_in}), int'(tv[0][8:6]));
    for (int e = 1; e <= 20 && done_at < 0; e++) begin
      @(posedge clk);
      #1;
      corrupt = (e <= 12) ? mask[e-1] : 6'd0;
      start   = pulse_mid && (e == 5) && (done_exp > 6);
      drv_exp = 0;
      if (e <= 11 && e < done_exp) drv_exp = int'(tv[e][8:6]);
      check($sformatf("%s drive_e%0d", tag, e), int'({bus.dut_reset, bus.dut_in}), drv_exp);
      if (done) done_at = e;
    end
    start   = 1'b0;
    corrupt = '0;
    check({tag, " done_edge"}, done_at, done_exp);
    check({tag, " pass_cnt"}, int'(pass_cnt), exp_p);
    check({tag, " fail_cnt"}, int'(fail_cnt), exp_f);
    check({tag, " any_fail"}, int'(any_fail), (exp_f > 0) ? 1 : 0);
    check({tag, " first_fail_idx"}, int'(first_fail_idx), exp_first);
    check({tag, " busy_in_done"}, int'(busy), 0);
    $display("run %s fault=%0d pass=%0d fail=%0d first=%0d done_edge=%0d",
             tag, fault_mode, pass_cnt, fail_cnt, first_fail_idx, done_at);
  endtask

  typedef struct {
    int         fault;
    int         cidx;
    logic [5:0] cmask;
    int         p_n, f_n, first_n;
    int         p_s, f_s, first_s;
    bit         pulse;
  } dir_t;

  dir_t dirs [7];

  initial begin
    int p, n, first, cidx;
    dirs[0] = '{0, -1, 6'd0,        12, 0, 0,   12, 0, 0,   1'b0};
    dirs[1] = '{1, -1, 6'd0,        10, 2, 10,  10, 1, 10,  1'b0};
    dirs[2] = '{2, -1, 6'd0,        3,  9, 0,   0,  1, 0,   1'b0};
    dirs[3] = '{0, 5,  6'b000_001,  11, 1, 5,   5,  1, 5,   1'b1};
    dirs[4] = '{0, 11, 6'b100_000,  11, 1, 11,  11, 1, 11,  1'b0};
    dirs[5] = '{0, 0,  6'b000_100,  11, 1, 0,   0,  1, 0,   1'b0};
    dirs[6] = '{0, -1, 6'd0,        12, 0, 0,   12, 0, 0,   1'b1};

    reset_n = 1'b0;
    start   = 1'b0;
    for (int k = 0; k < 12; k++) mask[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy_done", int'({busy, done}), 0);
    check("reset_counts", int'({pass_cnt, fail_cnt, any_fail, first_fail_idx}), 0);
    check("reset_drive", int'({bus.dut_reset, bus.dut_in}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_stays", int'({busy, done}), 0);

    for (int d = 0; d < 7; d++) begin
      for (int k = 0; k < 12; k++) mask[k] = '0;
      if (dirs[d].cidx >= 0) mask[dirs[d].cidx] = dirs[d].cmask;
      fault_mode = dirs[d].fault;
      do_run($sformatf("dir%0d", d), dirs[d].pulse,
             STOP ? dirs[d].p_s : dirs[d].p_n,
             STOP ? dirs[d].f_s : dirs[d].f_n,
             STOP ? dirs[d].first_s : dirs[d].first_n);
    end

    // Asynchronous reset in the middle of a run, then a clean run.
    for (int k = 0; k < 12; k++) mask[k] = '0;
    fault_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrun_reset_busy_done", int'({busy, done}), 0);
    check("midrun_reset_counts", int'({pass_cnt, fail_cnt, any_fail, first_fail_idx}), 0);
    check("midrun_reset_drive", int'({bus.dut_reset, bus.dut_in}), 0);
    @(negedge clk);
    reset_n = 1'b1;
    do_run("after_reset", 1'b0, 12, 0, 0);

    // Randomised faults and observation corruption against the scoring model.
    for (int r = 0; r < 24; r++) begin
      fault_mode = int'($urandom_range(0, 2));
      for (int k = 0; k < 12; k++)
        mask[k] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      cidx = int'($urandom_range(0, 1));
      model_run(fault_mode, p, n, first);
      do_run($sformatf("rnd%0d", r), cidx[0], p, n, first);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
